axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Shares the single AXI4 read master port between the instruction fetch unit and the load/store unit. Accepts one read-burst request at a time from either requester, forwards it on the AR channel, and routes the returning R beats back to the owner until `rlast`. Grants alternate round-robin so neither side starves; a beat counter checks `rlast` placement against the granted `arlen`.

## Interface
Parameters:
- `ADDR_W`, 64, AR address width
- `DATA_W`, 64, R data width

Ports (clock and reset first; `if_` = fetch requester, `ld_` = load requester, identical sets):
- `clk`  input  1  single clock, all state on rising edge
- `reset`  input  1  reset is asynchronous and active-low
- `if_arvalid` / `ld_arvalid`  input  1  request valid
- `if_arready` / `ld_arready`  output  1  request accepted this cycle
- `if_araddr` / `ld_araddr`  input  ADDR_W  burst start address
- `if_arlen` / `ld_arlen`  input  8  beats minus one
- `if_arsize` / `ld_arsize`  input  3  AXI size code
- `if_arburst` / `ld_arburst`  input  2  AXI burst type
- `if_rdata` / `ld_rdata`  output  DATA_W  returned data
- `if_rvalid` / `ld_rvalid`  output  1  beat valid to owner
- `if_rready` / `ld_rready`  input  1  owner accepts beat
- `if_rlast` / `ld_rlast`  output  1  last beat
- `m_axi_araddr`, `m_axi_arlen`, `m_axi_arsize`, `m_axi_arburst`, `m_axi_arvalid`  output  ADDR_W/8/3/2/1  shared AR channel
- `m_axi_arready`  input  1
- `m_axi_rdata`, `m_axi_rvalid`, `m_axi_rlast`  input  DATA_W/1/1  shared R channel
- `m_axi_rready`  output  1
- `busy`  output  1  high in ADDR or DATA
- `owner`  output  1  0 = fetch, 1 = load; valid when `busy`
- `protocol_err`  output  1  sticky; `rlast` misplaced

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: if exactly one `*_arvalid`, grant it; if both, grant the requester not granted last. Grant asserts that requester's `*_arready` combinationally the same cycle; AR fields captured into `m_axi_ar*` registers, `owner` registered, beat counter cleared, go ADDR.
- ADDR: `m_axi_arvalid` = 1; held with stable fields until `m_axi_arready`; then go DATA, `m_axi_arvalid` = 0 next cycle.
- DATA: R path combinational: owner `*_rvalid` = `m_axi_rvalid`, `*_rdata`/`*_rlast` = `m_axi_*`, `m_axi_rready` = owner `*_rready`. Non-owner `*_rvalid` = 0, `*_rdata` = 0. Each handshake increments 8-bit beat counter.
- Handshake with `m_axi_rlast`: go IDLE, last-grant pointer := owner.
- `protocol_err` set if `rlast` on beat index != captured arlen, or handshake at index == arlen without `rlast` (keep forwarding until `rlast`). Cleared only by reset.
- `*_arready` = 0 outside IDLE; no new request accepted while busy.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0, last-grant = load (fetch wins first tie), beat counter 0, `protocol_err` 0.
- Request at IDLE cycle N -> `*_arready` at N, `m_axi_arvalid` at N+1.
- `m_axi_arready` at cycle M (in ADDR) -> state DATA at M+1; earliest R beat forwarded at M+1.
- R forwarding: zero cycles latency, no buffering; backpressure passes straight through.
- Last beat at cycle L -> IDLE at L+1; next grant earliest L+1. Minimum turnaround: 1 idle cycle per burst.
- `m_axi_arready` high in IDLE ignored (arvalid low).
- Reset mid-burst: returns to IDLE immediately; in-flight AXI transaction abandoned (slave reset together by system).

## Structure
- Package `axi_arb_pkg`: state enum (IDLE/ADDR/DATA), requester enum (REQ_IF=0, REQ_LD=1), burst constants (FIXED=0, INCR=1, WRAP=2).
- Sub-module `rr_arb2`: 2-way round-robin grant from request pair and last-grant bit, purely combinational.

## Test plan
- Fetch only: `if_araddr`=0x1000, arlen=7, arburst=2; slave returns 8 beats -> `m_axi_araddr`=0x1000 at N+1, 8 beats on `if_r*`, `ld_rvalid` stays 0, `protocol_err`=0.
- Simultaneous requests after reset -> fetch granted first, load next burst; repeat -> grants alternate IF, LD, IF, LD.
- `m_axi_arready` delayed 5 cycles -> `m_axi_arvalid` and address stable for all 5; no `*_arready` re-pulse.
- Owner drops `rready` for 3 cycles mid-burst -> `m_axi_rready` low same cycles, beat count unchanged, no data lost.
- `rlast` on beat 3 of arlen=7 -> burst ends, `protocol_err`=1 and stays set; reset clears it.
- Reset asserted in DATA -> all outputs 0 asynchronously; after release, new fetch request granted normally.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and constants for the AXI read arbiter.
package axi_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {REQ_IF = 1'b0, REQ_LD = 1'b1} req_t;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; a tie goes to the side not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       gnt
);
  assign valid = |req;
  assign gnt   = &req ? ~last : req[1];
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI4 read master between fetch and load requesters,
// one burst at a time, with round-robin grants and rlast placement checking.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_arvalid,
  output logic              if_arready,
  input  logic [ADDR_W-1:0] if_araddr,
  input  logic [7:0]        if_arlen,
  input  logic [2:0]        if_arsize,
  input  logic [1:0]        if_arburst,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  input  logic              if_rready,
  output logic              if_rlast,
  input  logic              ld_arvalid,
  output logic              ld_arready,
  input  logic [ADDR_W-1:0] ld_araddr,
  input  logic [7:0]        ld_arlen,
  input  logic [2:0]        ld_arsize,
  input  logic [1:0]        ld_arburst,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  input  logic              ld_rready,
  output logic              ld_rlast,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rvalid,
  input  logic              m_axi_rlast,
  output logic              m_axi_rready,
  output logic              busy,
  output logic              owner,
  output logic              protocol_err
);
  state_t state, state_nx;
  req_t own_q, last_q;
  logic [7:0] beat_q;
  logic req_any, gnt, take, fwd_if, fwd_ld, hs;
  rr_arb2 u_arb (
    .req   ({ld_arvalid, if_arvalid}),
    .last  (last_q),
    .valid (req_any),
    .gnt   (gnt)
  );
  // gating with reset keeps arready low while reset is held
  assign take = reset && state == IDLE && req_any;
  assign if_arready = take && !gnt;
  assign ld_arready = take && gnt;
  assign fwd_if = state == DATA && own_q == REQ_IF;
  assign fwd_ld = state == DATA && own_q == REQ_LD;
  assign if_rvalid = fwd_if && m_axi_rvalid;
  assign if_rlast  = fwd_if && m_axi_rlast;
  assign if_rdata  = fwd_if ? m_axi_rdata : '0;
  assign ld_rvalid = fwd_ld && m_axi_rvalid;
  assign ld_rlast  = fwd_ld && m_axi_rlast;
  assign ld_rdata  = fwd_ld ? m_axi_rdata : '0;
  assign m_axi_rready = (fwd_if && if_rready) || (fwd_ld && ld_rready);
  assign hs = m_axi_rvalid && m_axi_rready;
  assign m_axi_arvalid = state == ADDR;
  assign busy = state != IDLE;
  assign owner = own_q;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && take)                ? ADDR :
               (state == ADDR && m_axi_arready)       ? DATA :
               (state == DATA && hs && m_axi_rlast)   ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_q         <= REQ_IF;
      last_q        <= REQ_LD;
      beat_q        <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
      protocol_err  <= 1'b0;
    end else begin
      if (take) begin
        own_q         <= req_t'(gnt);
        m_axi_araddr  <= gnt ? ld_araddr : if_araddr;
        m_axi_arlen   <= gnt ? ld_arlen : if_arlen;
        m_axi_arsize  <= gnt ? ld_arsize : if_arsize;
        m_axi_arburst <= gnt ? ld_arburst : if_arburst;
        beat_q        <= '0;
      end
      if (hs) begin
        beat_q <= beat_q + 8'd1;
        // rlast must land exactly on the beat whose index equals the granted arlen
        if (m_axi_rlast != (beat_q == m_axi_arlen)) protocol_err <= 1'b1;
        if (m_axi_rlast) last_q <= own_q;
      end
    end
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: scoreboard bench for axi_read_arbiter; grants and beats are
// queued when driven and compared when the DUT presents them.
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;
  typedef struct packed {logic [63:0] d; logic l;} beat_t;
  logic clk = 0;
  logic reset;
  logic if_arvalid, if_arready, if_rvalid, if_rready, if_rlast;
  logic [63:0] if_araddr, if_rdata;
  logic [7:0] if_arlen;
  logic [2:0] if_arsize;
  logic [1:0] if_arburst;
  logic ld_arvalid, ld_arready, ld_rvalid, ld_rready, ld_rlast;
  logic [63:0] ld_araddr, ld_rdata;
  logic [7:0] ld_arlen;
  logic [2:0] ld_arsize;
  logic [1:0] ld_arburst;
  logic [63:0] m_axi_araddr, m_axi_rdata;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic busy, owner, protocol_err;
  int chk = 0, pass = 0;
  logic exp_last;
  logic gq[$];
  beat_t bq[$];

  always #5 clk = ~clk;

  axi_read_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .if_arvalid(if_arvalid), .if_arready(if_arready), .if_araddr(if_araddr),
    .if_arlen(if_arlen), .if_arsize(if_arsize), .if_arburst(if_arburst),
    .if_rdata(if_rdata), .if_rvalid(if_rvalid), .if_rready(if_rready), .if_rlast(if_rlast),
    .ld_arvalid(ld_arvalid), .ld_arready(ld_arready), .ld_araddr(ld_araddr),
    .ld_arlen(ld_arlen), .ld_arsize(ld_arsize), .ld_arburst(ld_arburst),
    .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid), .ld_rready(ld_rready), .ld_rlast(ld_rlast),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
    .m_axi_rready(m_axi_rready), .busy(busy), .owner(owner), .protocol_err(protocol_err)
  );

  task automatic do_reset();
    reset = 0;
    {if_arvalid, ld_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast} = '0;
    {if_araddr, ld_araddr, m_axi_rdata} = '0;
    {if_arlen, ld_arlen, if_arsize, ld_arsize, if_arburst, ld_arburst} = '0;
    if_rready = 1;
    ld_rready = 1;
    exp_last = 1;
    gq.delete();
    bq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic run(input logic who, input logic both, input logic [63:0] addr,
                     input logic [7:0] len, input int ar_dly, input int last_idx,
                     input int stall_at, input logic exp_err, input int abort_at);
    logic e;
    logic [63:0] ea;
    beat_t b;
    if_araddr = addr;  if_arlen = len; if_arsize = 3'd3; if_arburst = BURST_WRAP;
    ld_araddr = addr ^ 64'h8000; ld_arlen = len; ld_arsize = 3'd2; ld_arburst = BURST_INCR;
    if_arvalid = both | ~who;
    ld_arvalid = both | who;
    gq.push_back(both ? ~exp_last : who);
    @(negedge clk);
    e = gq.pop_front();
    chk++;
    if ((e ? ld_arready : if_arready) !== 1'b1 || (e ? if_arready : ld_arready) !== 1'b0 || busy !== 1'b0)
      $display("FAIL grant: if_arready=%b ld_arready=%b busy=%b, required owner %0d", if_arready, ld_arready, busy, e);
    else pass++;
    @(posedge clk); #1;
    if_arvalid = 0;
    ld_arvalid = 0;
    ea = e ? addr ^ 64'h8000 : addr;
    for (int d = 0; d <= ar_dly; d++) begin
      m_axi_arready = (d == ar_dly);
      @(negedge clk);
      chk++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== ea || m_axi_arlen !== len ||
          m_axi_arsize !== (e ? 3'd2 : 3'd3) || m_axi_arburst !== (e ? BURST_INCR : BURST_WRAP) ||
          if_arready !== 1'b0 || ld_arready !== 1'b0 || busy !== 1'b1 || owner !== e)
        $display("FAIL ar_phase %0d: arvalid=%b araddr=%h arlen=%0d arready=%b%b owner=%b, required 1 %h %0d 00 %b",
                 d, m_axi_arvalid, m_axi_araddr, m_axi_arlen, if_arready, ld_arready, owner, ea, len, e);
      else pass++;
      @(posedge clk); #1;
    end
    m_axi_arready = 0;
    for (int i = 0; i <= last_idx; i++) begin
      if (i == abort_at) begin
        m_axi_rvalid = 1;
        m_axi_rdata = '1;
        #2 reset = 0;
        #1;
        chk++;
        if (busy !== 0 || if_rvalid !== 0 || ld_rvalid !== 0 || m_axi_rready !== 0 || if_rdata !== 0 ||
            m_axi_arvalid !== 0 || owner !== 0 || m_axi_araddr !== 0 || protocol_err !== 0)
          $display("FAIL async_reset: busy=%b rvalid=%b%b rready=%b araddr=%h, required all zero",
                   busy, if_rvalid, ld_rvalid, m_axi_rready, m_axi_araddr);
        else pass++;
        m_axi_rvalid = 0;
        m_axi_rdata = '0;
        exp_last = 1;
        return;
      end
      b.d = {addr[31:0], 24'h0, 8'(i)};
      b.l = (i == last_idx);
      m_axi_rvalid = 1;
      m_axi_rdata = b.d;
      m_axi_rlast = b.l;
      bq.push_back(b);
      if (i == stall_at) begin
        if (e) ld_rready = 0; else if_rready = 0;
        repeat (3) begin
          @(negedge clk);
          chk++;
          if (m_axi_rready !== 1'b0 || (e ? ld_rvalid : if_rvalid) !== 1'b1 || busy !== 1'b1)
            $display("FAIL stall: m_axi_rready=%b owner_rvalid=%b busy=%b, required 0 1 1",
                     m_axi_rready, e ? ld_rvalid : if_rvalid, busy);
          else pass++;
          @(posedge clk); #1;
        end
        if_rready = 1;
        ld_rready = 1;
      end
      @(negedge clk);
      b = bq.pop_front();
      chk++;
      if ((e ? ld_rvalid : if_rvalid) !== 1'b1 || (e ? ld_rdata : if_rdata) !== b.d ||
          (e ? ld_rlast : if_rlast) !== b.l || (e ? if_rvalid : ld_rvalid) !== 1'b0 ||
          (e ? if_rdata : ld_rdata) !== 64'h0 || m_axi_rready !== 1'b1)
        $display("FAIL beat %0d: rvalid=%b rdata=%h rlast=%b other_rvalid=%b rready=%b, required 1 %h %b 0 1",
                 i, e ? ld_rvalid : if_rvalid, e ? ld_rdata : if_rdata, e ? ld_rlast : if_rlast,
                 e ? if_rvalid : ld_rvalid, m_axi_rready, b.d, b.l);
      else pass++;
      @(posedge clk); #1;
    end
    m_axi_rvalid = 0;
    m_axi_rlast = 0;
    exp_last = e;
    @(negedge clk);
    chk++;
    if (busy !== 1'b0 || protocol_err !== exp_err || if_rvalid !== 0 || ld_rvalid !== 0)
      $display("FAIL burst_end: busy=%b protocol_err=%b, required 0 %b", busy, protocol_err, exp_err);
    else pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    if_arvalid = 1;
    reset = 0;
    #1;
    chk++;
    if (if_arready !== 1'b0)
      $display("FAIL reset_arready: if_arready=%b, required 0", if_arready);
    else pass++;
    do_reset();
    @(negedge clk);
    chk++;
    if (busy !== 0 || m_axi_arvalid !== 0 || protocol_err !== 0 || owner !== 0 ||
        m_axi_rready !== 0 || if_rvalid !== 0 || ld_rvalid !== 0 || m_axi_araddr !== 0)
      $display("FAIL reset_state: busy=%b arvalid=%b err=%b owner=%b rready=%b, required 0",
               busy, m_axi_arvalid, protocol_err, owner, m_axi_rready);
    else pass++;
    @(posedge clk); #1;
    m_axi_arready = 1;
    @(negedge clk);
    chk++;
    if (m_axi_arvalid !== 0 || busy !== 0)
      $display("FAIL idle_arready: arvalid=%b busy=%b, required 0 0", m_axi_arvalid, busy);
    else pass++;
    @(posedge clk); #1;
    m_axi_arready = 0;
  endtask

  task automatic test_fetch_only();
    run(0, 0, 64'h1000, 8'd7, 0, 7, -1, 0, -1);
  endtask

  task automatic test_round_robin();
    do_reset();
    run(0, 1, 64'h2000, 8'd1, 0, 1, -1, 0, -1);
    run(0, 1, 64'h2100, 8'd0, 0, 0, -1, 0, -1);
    run(0, 1, 64'h2200, 8'd3, 0, 3, -1, 0, -1);
    run(0, 1, 64'h2300, 8'd2, 0, 2, -1, 0, -1);
  endtask

  task automatic test_ar_delay();
    run(1, 0, 64'h3000, 8'd3, 5, 3, -1, 0, -1);
  endtask

  task automatic test_backpressure();
    run(0, 0, 64'h4000, 8'd5, 0, 5, 2, 0, -1);
    run(1, 0, 64'h4100, 8'd3, 1, 3, 3, 0, -1);
  endtask

  task automatic test_early_rlast();
    run(0, 0, 64'h5000, 8'd7, 0, 3, -1, 1, -1);
    run(1, 0, 64'h5100, 8'd1, 0, 1, -1, 1, -1);
    do_reset();
    @(negedge clk);
    chk++;
    if (protocol_err !== 1'b0)
      $display("FAIL err_cleared: protocol_err=%b, required 0", protocol_err);
    else pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_late_rlast();
    run(1, 0, 64'h6000, 8'd3, 0, 5, -1, 1, -1);
    do_reset();
  endtask

  task automatic test_reset_in_data();
    run(1, 0, 64'h7000, 8'd7, 1, 7, -1, 0, 3);
    @(posedge clk); #1;
    reset = 1;
    run(0, 1, 64'h7800, 8'd2, 0, 2, -1, 0, -1);
  endtask

  initial begin
    reset = 0;
    test_reset();
    test_fetch_only();
    test_round_robin();
    test_ar_delay();
    test_backpressure();
    test_early_rlast();
    test_late_rlast();
    test_reset_in_data();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
